// File: rtl/regfile_fwd_n_pkg.sv
// Shared definitions for the forwarding register file.
// Holds default widths, the zero-register address, the write-enable level and the enum that
// names which forward source a read port selects.
package regfile_fwd_n_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;

  localparam int unsigned ZERO_REG     = 0;
  localparam logic        WRITE_ENABLE = 1'b1;

  // Read-port source select, in priority order (youngest producer first).
  typedef enum logic [2:0] {
    SrcZero,
    SrcEx,
    SrcMem,
    SrcWb,
    SrcArr
  } fwd_src_e;

endpackage

// File: rtl/regfile_fwd_n_if.sv
// Bus between the pipeline (master) and the register file (slave).
// Carries read addresses/data/stall, EX/MEM/WB forward sources, the WB write port and the
// debug read port. Read port k uses rd_addr_i[k*ADDR_W +: ADDR_W], rd_data_o[k*DATA_W +: DATA_W].
interface regfile_fwd_n_if
  import regfile_fwd_n_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;
  logic                     rd_stall_o;

  logic                     ex_w_e_i;
  logic [ADDR_W-1:0]        ex_w_addr_i;
  logic [DATA_W-1:0]        ex_w_data_i;
  logic                     ex_is_load_i;

  logic                     mem_w_e_i;
  logic [ADDR_W-1:0]        mem_w_addr_i;
  logic [DATA_W-1:0]        mem_w_data_i;
  logic                     mem_valid_i;

  logic                     wb_w_e_i;
  logic [ADDR_W-1:0]        wb_w_addr_i;
  logic [DATA_W-1:0]        wb_w_data_i;

  logic [ADDR_W-1:0]        dbg_addr_i;
  logic [DATA_W-1:0]        dbg_data_o;

  modport master (
    output rd_addr_i,
    input  rd_data_o, rd_stall_o,
    output ex_w_e_i, ex_w_addr_i, ex_w_data_i, ex_is_load_i,
    output mem_w_e_i, mem_w_addr_i, mem_w_data_i, mem_valid_i,
    output wb_w_e_i, wb_w_addr_i, wb_w_data_i,
    output dbg_addr_i,
    input  dbg_data_o
  );

  modport slave (
    input  rd_addr_i,
    output rd_data_o, rd_stall_o,
    input  ex_w_e_i, ex_w_addr_i, ex_w_data_i, ex_is_load_i,
    input  mem_w_e_i, mem_w_addr_i, mem_w_data_i, mem_valid_i,
    input  wb_w_e_i, wb_w_addr_i, wb_w_data_i,
    input  dbg_addr_i,
    output dbg_data_o
  );

endinterface

// File: rtl/regfile_fwd_port.sv
// One combinational read port with EX/MEM/WB forwarding and load-use stall.
// Ports: rd_addr_i (read address), arr_data_i (array entry at rd_addr_i), ex_/mem_/wb_ forward
// sources, rd_data_o (selected data), rd_stall_o (selected source has no valid data yet).
module regfile_fwd_port
  import regfile_fwd_n_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              ex_w_e_i,
  input  logic [ADDR_W-1:0] ex_w_addr_i,
  input  logic [DATA_W-1:0] ex_w_data_i,
  input  logic              ex_is_load_i,
  input  logic              mem_w_e_i,
  input  logic [ADDR_W-1:0] mem_w_addr_i,
  input  logic [DATA_W-1:0] mem_w_data_i,
  input  logic              mem_valid_i,
  input  logic              wb_w_e_i,
  input  logic [ADDR_W-1:0] wb_w_addr_i,
  input  logic [DATA_W-1:0] wb_w_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_stall_o
);

  fwd_src_e src;

  // Youngest matching producer wins, even if it cannot deliver data yet (it then stalls).
  always_comb begin
    src = SrcArr;
    if (rd_addr_i == ADDR_W'(ZERO_REG)) begin
      src = SrcZero;
    end else if (ex_w_e_i == WRITE_ENABLE && ex_w_addr_i == rd_addr_i) begin
      src = SrcEx;
    end else if (mem_w_e_i == WRITE_ENABLE && mem_w_addr_i == rd_addr_i) begin
      src = SrcMem;
    end else if (wb_w_e_i == WRITE_ENABLE && wb_w_addr_i == rd_addr_i) begin
      src = SrcWb;
    end
  end

  always_comb begin
    rd_data_o  = '0;
    rd_stall_o = 1'b0;
    case (src)
      SrcEx: begin
        rd_data_o  = ex_w_data_i;
        rd_stall_o = ex_is_load_i;
      end
      SrcMem: begin
        rd_data_o  = mem_w_data_i;
        rd_stall_o = ~mem_valid_i;
      end
      SrcWb:   rd_data_o = wb_w_data_i;
      SrcArr:  rd_data_o = arr_data_i;
      default: rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_fwd_n.sv
// Integer register file for the 5-stage pipe.
// Ports: clk_100MHz (clock), arst_n (async active-low reset), rf (slave side of
// regfile_fwd_n_if: NUM_RD forwarding read ports, stall, WB write port, registered debug read).
// Entry 0 reads as zero; writes to it are dropped so its flop never leaves reset.
module regfile_fwd_n
  import regfile_fwd_n_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = DEF_NUM_RD
) (
  input  logic           clk_100MHz,
  input  logic           arst_n,
  regfile_fwd_n_if.slave rf
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem_q [Depth];
  logic [DATA_W-1:0]        dbg_q;
  logic [NUM_RD*DATA_W-1:0] port_data;
  logic [NUM_RD-1:0]        port_stall;

  always_ff @(posedge clk_100MHz or negedge arst_n) begin
    if (!arst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      dbg_q <= '0;
    end else begin
      if (rf.wb_w_e_i == WRITE_ENABLE && rf.wb_w_addr_i != ADDR_W'(ZERO_REG)) begin
        mem_q[rf.wb_w_addr_i] <= rf.wb_w_data_i;
      end
      // Reads the pre-write array: no bypass on the debug path.
      dbg_q <= mem_q[rf.dbg_addr_i];
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    regfile_fwd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .rd_addr_i    (rf.rd_addr_i[k*ADDR_W +: ADDR_W]),
      .arr_data_i   (mem_q[rf.rd_addr_i[k*ADDR_W +: ADDR_W]]),
      .ex_w_e_i     (rf.ex_w_e_i),
      .ex_w_addr_i  (rf.ex_w_addr_i),
      .ex_w_data_i  (rf.ex_w_data_i),
      .ex_is_load_i (rf.ex_is_load_i),
      .mem_w_e_i    (rf.mem_w_e_i),
      .mem_w_addr_i (rf.mem_w_addr_i),
      .mem_w_data_i (rf.mem_w_data_i),
      .mem_valid_i  (rf.mem_valid_i),
      .wb_w_e_i     (rf.wb_w_e_i),
      .wb_w_addr_i  (rf.wb_w_addr_i),
      .wb_w_data_i  (rf.wb_w_data_i),
      .rd_data_o    (port_data[k*DATA_W +: DATA_W]),
      .rd_stall_o   (port_stall[k])
    );
  end

  // Forward paths bypass the array, so reset must also mask the combinational outputs.
  assign rf.rd_data_o  = arst_n ? port_data : '0;
  assign rf.rd_stall_o = arst_n & (|port_stall);
  assign rf.dbg_data_o = dbg_q;

endmodule
